riscv_register_file_mp: RTL and testbench

- Parametrised multi-port integer/FP register file for the next RI5CY-class core.
- Flip-flop storage with configurable read-port and write-port counts, an optional FP bank, and a per-register pending scoreboard for long-latency writebacks (FPU, divider, LSU).
- Sits in the ID stage; read data and busy flags feed operand muxes and hazard logic.

---
 rtl/riscv_rf_pkg.sv | 14 +
 rtl/riscv_rf_scoreboard.sv | 54 +++++
 rtl/riscv_register_file_mp.sv | 88 ++++++++
 tb/tb_riscv_register_file_mp.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/riscv_rf_pkg.sv
// riscv_rf_pkg: shared sizes, bank-count helper and pending-vector type for the register file.
package riscv_rf_pkg;
    localparam int NUM_INT_WORDS = 32;
    localparam int NUM_FP_WORDS  = 32;
    localparam int MAX_WORDS     = NUM_INT_WORDS + NUM_FP_WORDS;
    localparam int IDX_WIDTH     = 6;
    localparam int CNT_WIDTH     = 7;

    typedef logic [MAX_WORDS-1:0] rf_pending_t;

    function automatic int rf_num_words(input int fpu, input int zfinx);
        return (fpu != 0 && zfinx == 0) ? NUM_INT_WORDS + NUM_FP_WORDS : NUM_INT_WORDS;
    endfunction
endpackage

// File: rtl/riscv_rf_scoreboard.sv
// riscv_rf_scoreboard: per-register pending bits, reservation handshake, pending count and read busy flags.
// RISCV_RF_BYPASS_EN makes busy flags follow the same-cycle write/reservation outcome.
module riscv_rf_scoreboard
    import riscv_rf_pkg::*;
#(
    parameter int NUM_RPORTS = 3
)(
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  rf_pending_t                            wclr,
    input  logic [IDX_WIDTH-1:0]                   rsv_idx,
    input  logic                                   rsv_valid,
    input  logic [NUM_RPORTS-1:0][IDX_WIDTH-1:0]   ridx,
    output logic                                   rsv_ready,
    output logic [NUM_RPORTS-1:0]                  rbusy,
    output logic [CNT_WIDTH-1:0]                   pending_cnt
);
    rf_pending_t pending, rsv_hot;
    logic take;
    logic [CNT_WIDTH-1:0] n_clr;

    assign rsv_ready = !pending[rsv_idx] || wclr[rsv_idx];
    assign take      = rsv_valid && rsv_ready && rsv_idx != '0;
    assign rsv_hot   = take ? rf_pending_t'(1) << rsv_idx : '0;

    // Several write ports may retire different pending registers in one cycle.
    always_comb begin
        n_clr = '0;
        for (int i = 0; i < MAX_WORDS; i++)
            n_clr = n_clr + CNT_WIDTH'(pending[i] & wclr[i]);
    end

    always_comb begin
        for (int r = 0; r < NUM_RPORTS; r++)
`ifdef RISCV_RF_BYPASS_EN
            rbusy[r] = wclr[ridx[r]] ? rsv_hot[ridx[r]] : pending[ridx[r]];
`else
            rbusy[r] = pending[ridx[r]];
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending     <= '0;
            pending_cnt <= '0;
        end else begin
            pending     <= (pending & ~wclr) | rsv_hot;
            pending_cnt <= pending_cnt - n_clr + CNT_WIDTH'(take);
        end
    end

    cnt_matches_popcount: assert property (@(posedge clk) disable iff (!rst_n)
        pending_cnt == CNT_WIDTH'($countones(pending)));
endmodule

// File: rtl/riscv_register_file_mp.sv
// riscv_register_file_mp: multi-port flop register file with optional FP bank and pending scoreboard.
// Define RISCV_RF_BYPASS_EN to forward same-cycle write data to the read ports.
module riscv_register_file_mp
    import riscv_rf_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_RPORTS = 3,
    parameter int NUM_WPORTS = 2,
    parameter int FPU        = 0,
    parameter int Zfinx      = 0
)(
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [NUM_RPORTS-1:0][ADDR_WIDTH-1:0]  raddr_i,
    output logic [NUM_RPORTS-1:0][DATA_WIDTH-1:0]  rdata_o,
    output logic [NUM_RPORTS-1:0]                  rbusy_o,
    input  logic [NUM_WPORTS-1:0][ADDR_WIDTH-1:0]  waddr_i,
    input  logic [NUM_WPORTS-1:0][DATA_WIDTH-1:0]  wdata_i,
    input  logic [NUM_WPORTS-1:0]                  we_i,
    input  logic [ADDR_WIDTH-1:0]                  rsv_addr_i,
    input  logic                                   rsv_valid_i,
    output logic                                   rsv_ready_o,
    output logic [CNT_WIDTH-1:0]                   pending_cnt_o
);
    localparam int NW = rf_num_words(FPU, Zfinx);
    localparam int IW = $clog2(NW);

    logic [DATA_WIDTH-1:0] mem [NW];
    logic [NUM_RPORTS-1:0][IDX_WIDTH-1:0] ridx;
    logic [NUM_WPORTS-1:0][IDX_WIDTH-1:0] widx;
    logic [IDX_WIDTH-1:0] rsv_idx;
    rf_pending_t wclr;

    // With a single bank, address bit 5 aliases onto the integer registers.
    function automatic logic [IDX_WIDTH-1:0] to_idx(input logic [ADDR_WIDTH-1:0] a);
        logic [IDX_WIDTH-1:0] k;
        k = IDX_WIDTH'(a);
        k[IDX_WIDTH-1] = (NW == MAX_WORDS) ? k[IDX_WIDTH-1] : 1'b0;
        return k;
    endfunction

    always_comb begin
        for (int r = 0; r < NUM_RPORTS; r++) ridx[r] = to_idx(raddr_i[r]);
        for (int p = 0; p < NUM_WPORTS; p++) widx[p] = to_idx(waddr_i[p]);
        rsv_idx = to_idx(rsv_addr_i);
    end

    always_comb begin
        wclr = '0;
        for (int p = 0; p < NUM_WPORTS; p++)
            if (we_i[p]) wclr[widx[p]] = 1'b1;
        wclr[0] = 1'b0;
    end

    // Later ports override earlier ones, so the highest port index wins a collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NW; i++) mem[i] <= '0;
        end else begin
            for (int p = 0; p < NUM_WPORTS; p++)
                if (we_i[p] && widx[p] != '0) mem[widx[p][IW-1:0]] <= wdata_i[p];
        end
    end

    always_comb begin
        for (int r = 0; r < NUM_RPORTS; r++) begin
            rdata_o[r] = mem[ridx[r][IW-1:0]];
`ifdef RISCV_RF_BYPASS_EN
            for (int p = 0; p < NUM_WPORTS; p++)
                if (we_i[p] && widx[p] == ridx[r]) rdata_o[r] = wdata_i[p];
`endif
            rdata_o[r] = (ridx[r] == '0) ? '0 : rdata_o[r];
        end
    end

    riscv_rf_scoreboard #(.NUM_RPORTS(NUM_RPORTS)) u_sb (
        .clk         (clk),
        .rst_n       (rst_n),
        .wclr        (wclr),
        .rsv_idx     (rsv_idx),
        .rsv_valid   (rsv_valid_i),
        .ridx        (ridx),
        .rsv_ready   (rsv_ready_o),
        .rbusy       (rbusy_o),
        .pending_cnt (pending_cnt_o)
    );
endmodule

// File: tb/tb_riscv_register_file_mp.sv
// tb_riscv_register_file_mp: directed checks of the dual-bank register file (FPU=1, ADDR_WIDTH=6).
module tb_riscv_register_file_mp;
`ifdef RISCV_RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk, rst_n;
    logic [2:0][5:0]  raddr;
    logic [2:0][31:0] rdata;
    logic [2:0]       rbusy;
    logic [1:0][5:0]  waddr;
    logic [1:0][31:0] wdata;
    logic [1:0]       we;
    logic [5:0]       rsv_addr;
    logic             rsv_valid, rsv_ready;
    logic [6:0]       cnt;
    int n_cmp = 0;
    int n_err = 0;

    riscv_register_file_mp #(
        .ADDR_WIDTH(6), .DATA_WIDTH(32), .NUM_RPORTS(3), .NUM_WPORTS(2), .FPU(1), .Zfinx(0)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .raddr_i(raddr), .rdata_o(rdata), .rbusy_o(rbusy),
        .waddr_i(waddr), .wdata_i(wdata), .we_i(we),
        .rsv_addr_i(rsv_addr), .rsv_valid_i(rsv_valid), .rsv_ready_o(rsv_ready),
        .pending_cnt_o(cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = '0;
        rsv_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; raddr = '0; waddr = '0; wdata = '0; we = '0; rsv_addr = '0; rsv_valid = 1'b0;
        #12 rst_n = 1'b1;
        // every address on every port reads zero and idle after reset
        for (int a = 0; a < 64; a += 3) begin
            for (int r = 0; r < 3; r++) raddr[r] = 6'((a + r) % 64);
            #1;
            for (int r = 0; r < 3; r++) begin
                chk("rst_rdata", rdata[r], 32'h0);
                chk("rst_rbusy", 32'(rbusy[r]), 32'h0);
            end
        end
        chk("rst_cnt", 32'(cnt), 32'd0);
        rsv_addr = 6'd7;
        #1 chk("rst_ready", 32'(rsv_ready), 32'd1);

        tick();
        waddr[0] = 6'd5; waddr[1] = 6'd5; wdata[0] = 32'h1111_1111; wdata[1] = 32'h2222_2222; we = 2'b11;
        raddr[0] = 6'd5;
        #1 chk("coll_same_cycle", rdata[0], BYP ? 32'h2222_2222 : 32'h0);
        tick(); idle();
        #1 chk("coll_hi_port_wins", rdata[0], 32'h2222_2222);

        rsv_addr = 6'd7; rsv_valid = 1'b1;
        #1 chk("rsv7_ready", 32'(rsv_ready), 32'd1);
        tick(); idle(); raddr[0] = 6'd7;
        #1 chk("rsv7_cnt", 32'(cnt), 32'd1);
        chk("rsv7_busy", 32'(rbusy[0]), 32'd1);
        rsv_valid = 1'b1;
        #1 chk("rsv7_again_ready", 32'(rsv_ready), 32'd0);
        tick(); idle();
        #1 chk("rsv7_no_stack_cnt", 32'(cnt), 32'd1);

        we = 2'b01; waddr[0] = 6'd7; wdata[0] = 32'hDEAD_BEEF;
        #1 chk("wr7_ready_on_clear", 32'(rsv_ready), 32'd1);
        chk("wr7_busy_same", 32'(rbusy[0]), BYP ? 32'd0 : 32'd1);
        tick(); idle();
        #1 chk("wr7_busy", 32'(rbusy[0]), 32'd0);
        chk("wr7_cnt", 32'(cnt), 32'd0);
        chk("wr7_data", rdata[0], 32'hDEAD_BEEF);

        rsv_addr = 6'd9; rsv_valid = 1'b1;
        tick(); idle();
        #1 chk("rsv9_cnt", 32'(cnt), 32'd1);
        we = 2'b01; waddr[0] = 6'd9; wdata[0] = 32'h1234_5678; rsv_valid = 1'b1; raddr[0] = 6'd9;
        #1 chk("wr_rsv9_ready", 32'(rsv_ready), 32'd1);
        chk("wr_rsv9_busy_same", 32'(rbusy[0]), 32'd1);
        tick(); idle();
        #1 chk("wr_rsv9_data", rdata[0], 32'h1234_5678);
        chk("wr_rsv9_busy", 32'(rbusy[0]), 32'd1);
        chk("wr_rsv9_cnt", 32'(cnt), 32'd1);
        we = 2'b01; wdata[0] = 32'h0BAD_F00D;
        tick(); idle();
        #1 chk("clr9_cnt", 32'(cnt), 32'd0);
        chk("clr9_busy", 32'(rbusy[0]), 32'd0);

        we = 2'b01; waddr[0] = 6'd0; wdata[0] = 32'hFFFF_FFFF; rsv_addr = 6'd0; rsv_valid = 1'b1; raddr[0] = 6'd0;
        #1 chk("x0_ready", 32'(rsv_ready), 32'd1);
        chk("x0_rdata_same", rdata[0], 32'h0);
        chk("x0_busy_same", 32'(rbusy[0]), 32'd0);
        tick(); idle();
        #1 chk("x0_rdata", rdata[0], 32'h0);
        chk("x0_busy", 32'(rbusy[0]), 32'd0);
        chk("x0_cnt", 32'(cnt), 32'd0);

        rsv_addr = 6'd10; rsv_valid = 1'b1;
        tick(); rsv_addr = 6'd11;
        tick(); idle();
        raddr[0] = 6'd10; raddr[1] = 6'd11; raddr[2] = 6'd0;
        #1 chk("two_rsv_cnt", 32'(cnt), 32'd2);
        chk("two_rsv_busy", 32'(rbusy), 32'b011);
        we = 2'b11; waddr[0] = 6'd10; waddr[1] = 6'd11; wdata[0] = 32'hA; wdata[1] = 32'hB;
        tick(); idle();
        #1 chk("two_clr_cnt", 32'(cnt), 32'd0);
        chk("two_clr_busy", 32'(rbusy), 32'b000);
        chk("two_clr_d10", rdata[0], 32'hA);
        chk("two_clr_d11", rdata[1], 32'hB);

        we = 2'b10; waddr[1] = 6'h20; wdata[1] = 32'hA5A5_A5A5;
        tick(); idle();
        raddr[0] = 6'h20; raddr[1] = 6'd0;
        #1 chk("f0_data", rdata[0], 32'hA5A5_A5A5);
        chk("f0_x0_zero", rdata[1], 32'h0);
        rsv_addr = 6'h20; rsv_valid = 1'b1;
        #1 chk("f0_ready", 32'(rsv_ready), 32'd1);
        tick(); idle();
        #1 chk("f0_cnt", 32'(cnt), 32'd1);
        chk("f0_busy", 32'(rbusy[0]), 32'd1);

        we = 2'b01; waddr[0] = 6'd3; wdata[0] = 32'h3333_3333; raddr[2] = 6'd3;
        #1 chk("byp_x3_same", rdata[2], BYP ? 32'h3333_3333 : 32'h0);
        tick(); idle();
        #1 chk("byp_x3_next", rdata[2], 32'h3333_3333);

        raddr[0] = 6'd5; raddr[1] = 6'h20; raddr[2] = 6'd7;
        #1 chk("pre_rst_x5", rdata[0], 32'h2222_2222);
        #3 rst_n = 1'b0;
        #1 chk("mid_rst_x5", rdata[0], 32'h0);
        chk("mid_rst_f0", rdata[1], 32'h0);
        chk("mid_rst_x7", rdata[2], 32'h0);
        chk("mid_rst_busy", 32'(rbusy), 32'b000);
        chk("mid_rst_cnt", 32'(cnt), 32'd0);
        #2 rst_n = 1'b1;
        tick();
        chk("post_rst_x5", rdata[0], 32'h0);
        chk("post_rst_cnt", 32'(cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
